// File: rtl/mask_patch_serializer.sv
// Captures one raster-order 1-bit mask frame and replays it in patch-serial order
// (FILTER_SIZE x FILTER_SIZE patches, row-major) with a continuous valid burst.
module mask_patch_serializer #(
    parameter int unsigned FILTER_SIZE = 5,
    parameter int unsigned CAM_WIDTH   = 240,
    parameter int unsigned CAM_HEIGHT  = 320
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    input  logic        valid_in,
    output logic        mask_ds_out,
    output logic        valid_ds_out,
    output logic        busy_out
);

    localparam int unsigned DS_W      = CAM_WIDTH / FILTER_SIZE;
    localparam int unsigned DS_H      = CAM_HEIGHT / FILTER_SIZE;
    localparam int unsigned MEM_DEPTH = CAM_WIDTH * CAM_HEIGHT;
    localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned FW        = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int unsigned PCW       = (DS_W > 1) ? $clog2(DS_W) : 1;
    localparam int unsigned PRW       = (DS_H > 1) ? $clog2(DS_H) : 1;

    localparam logic [FW-1:0]  D_LAST     = FW'(FILTER_SIZE - 1);
    localparam logic [PCW-1:0] PC_LAST    = PCW'(DS_W - 1);
    localparam logic [PRW-1:0] PR_LAST    = PRW'(DS_H - 1);
    localparam logic [10:0]    H_LAST     = 11'(CAM_WIDTH - 1);
    localparam logic [9:0]     V_LAST     = 10'(CAM_HEIGHT - 1);
    localparam logic [AW-1:0]  ROW_STEP   = AW'(CAM_WIDTH);
    localparam logic [AW-1:0]  COL_STEP   = AW'(FILTER_SIZE);
    localparam logic [AW-1:0]  ROW_REWIND = AW'((FILTER_SIZE - 1) * CAM_WIDTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, READ, DRAIN} state_t;

    state_t         state;
    state_t         state_next;
    logic           drain_cnt;
    logic           wr_en_c;
    logic           issue_c;
    logic           last_c;
    logic           is_origin_c;
    logic           in_range_c;
    logic           is_final_c;
    logic [AW-1:0]  wr_addr_c;
    logic [AW-1:0]  rd_addr_c;

    logic [FW-1:0]  dx;
    logic [FW-1:0]  dy;
    logic [PCW-1:0] pc;
    logic [PRW-1:0] pr;
    logic [AW-1:0]  row_base;
    logic [AW-1:0]  col_base;

    logic [AW-1:0]  rd_addr;
    logic           issue_q;
    logic           issue_d1;
    logic           mem_q;
    logic           mem [MEM_DEPTH];

    assign is_origin_c = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign in_range_c  = (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
    assign is_final_c  = (hcount_in == H_LAST) && (vcount_in == V_LAST);
    assign wr_addr_c   = AW'(32'(vcount_in) * CAM_WIDTH + 32'(hcount_in));
    assign rd_addr_c   = row_base + col_base + AW'(dx);
    assign last_c      = (dx == D_LAST) && (dy == D_LAST) && (pc == PC_LAST) && (pr == PR_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_en_c    = 1'b0;
        issue_c    = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in && is_origin_c) begin
                    wr_en_c    = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (valid_in && in_range_c) begin
                    wr_en_c = 1'b1;
                    if (is_final_c) state_next = READ;
                end
            end
            READ: begin
                issue_c = 1'b1;
                if (last_c) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || state != DRAIN) drain_cnt <= 1'b0;
        else                          drain_cnt <= 1'b1;
    end

    // Patch-order address walk: row_base tracks (pr*F+dy)*W, col_base tracks pc*F.
    always_ff @(posedge clk_in) begin
        if (rst_in || !issue_c || last_c) begin
            dx       <= '0;
            dy       <= '0;
            pc       <= '0;
            pr       <= '0;
            row_base <= '0;
            col_base <= '0;
        end else if (dx != D_LAST) begin
            dx <= dx + 1'b1;
        end else begin
            dx <= '0;
            if (dy != D_LAST) begin
                dy       <= dy + 1'b1;
                row_base <= row_base + ROW_STEP;
            end else begin
                dy <= '0;
                if (pc != PC_LAST) begin
                    pc       <= pc + 1'b1;
                    col_base <= col_base + COL_STEP;
                    row_base <= row_base - ROW_REWIND;
                end else begin
                    pc       <= '0;
                    col_base <= '0;
                    pr       <= pr + 1'b1;
                    row_base <= row_base + ROW_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en_c && !rst_in) mem[wr_addr_c] <= mask_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) mem_q <= 1'b0;
        else        mem_q <= mem[rd_addr];
    end

    // Strobe pipeline aligned with the two-cycle memory read; data holds while idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_addr      <= '0;
            issue_q      <= 1'b0;
            issue_d1     <= 1'b0;
            valid_ds_out <= 1'b0;
            mask_ds_out  <= 1'b0;
            busy_out     <= 1'b0;
        end else begin
            issue_q      <= issue_c;
            if (issue_c) rd_addr <= rd_addr_c;
            issue_d1     <= issue_q;
            valid_ds_out <= issue_d1;
            if (issue_d1) mask_ds_out <= mem_q;
            busy_out     <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mask_patch_serializer.sv
// Directed bench for mask_patch_serializer: three small configurations share one
// pixel bus; each has its own valid and its own output monitor.
module tb_mask_patch_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        mk;
    logic [2:0]  vin;
    logic [2:0]  vds;
    logic [2:0]  mds;
    logic [2:0]  bsy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   cnt [3];
    int   bursts [3];
    int   ones [3];
    int   rise_cyc [3];
    int   wr_cyc;
    logic [2:0] prev;
    logic cap [3][0:127];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mask_patch_serializer #(.FILTER_SIZE(2), .CAM_WIDTH(4), .CAM_HEIGHT(4)) dut_a (
        .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc), .mask_in(mk),
        .valid_in(vin[0]), .mask_ds_out(mds[0]), .valid_ds_out(vds[0]), .busy_out(bsy[0]));

    mask_patch_serializer #(.FILTER_SIZE(2), .CAM_WIDTH(5), .CAM_HEIGHT(5)) dut_b (
        .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc), .mask_in(mk),
        .valid_in(vin[1]), .mask_ds_out(mds[1]), .valid_ds_out(vds[1]), .busy_out(bsy[1]));

    mask_patch_serializer #(.FILTER_SIZE(5), .CAM_WIDTH(12), .CAM_HEIGHT(11)) dut_c (
        .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc), .mask_in(mk),
        .valid_in(vin[2]), .mask_ds_out(mds[2]), .valid_ds_out(vds[2]), .busy_out(bsy[2]));

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vds[k] === 1'b1) begin
                if (prev[k] !== 1'b1) begin
                    bursts[k]++;
                    rise_cyc[k] = cyc;
                end
                if (cnt[k] < 128) cap[k][cnt[k]] = mds[k];
                cnt[k]++;
                if (mds[k] === 1'b1) ones[k]++;
            end
            prev[k] = vds[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 3; k++) begin
            cnt[k]    = 0;
            bursts[k] = 0;
            ones[k]   = 0;
        end
    endtask

    function automatic logic pix(input int pat, input int x, input int y, input int w, input int h);
        case (pat)
            0:       return x[0];
            1:       return (x < w - 1) && (y < h - 1);
            2:       return (x == 2) && (y == 1);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic send(input int k, input int w, input int h, input int pat, input int start);
        for (int i = start; i < w * h; i++) begin
            hc  = 11'(i % w);
            vc  = 10'(i / w);
            mk  = pix(pat, i % w, i / w, w, h);
            vin = 3'(1 << k);
            @(posedge clk);
            #1;
        end
        vin    = 3'b000;
        wr_cyc = cyc;
    endtask

    task automatic wait_done(input int k, input string tag);
        int n;
        n = 0;
        while ((bsy[k] !== 1'b0 || vds[k] !== 1'b0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= 2000), 32'd0);
    endtask

    function automatic logic [15:0] burst16(input int k);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[15 - i] = cap[k][i];
        return v;
    endfunction

    initial begin
        int seen;
        int n;
        rst  = 1'b1;
        vin  = 3'b000;
        hc   = '0;
        vc   = '0;
        mk   = 1'b0;
        prev = 3'b000;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(vds), 32'd0);
        check("rst_busy",  32'(bsy), 32'd0);
        check("rst_mask",  32'(mds), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // alternating columns on 4x4, F=2
        clear_mon();
        send(0, 4, 4, 0, 0);
        check("a1_busy_read", 32'(bsy[0]), 32'd1);
        wait_done(0, "a1");
        check("a1_rise_delay", 32'(rise_cyc[0] - wr_cyc), 32'd3);
        check("a1_bursts", 32'(bursts[0]), 32'd1);
        check("a1_len", 32'(cnt[0]), 32'd16);
        check("a1_data", 32'(burst16(0)), 32'h5555);
        check("a1_mask_hold", 32'(mds[0]), 32'd1);
        check("a1_valid_low", 32'(vds[0]), 32'd0);

        // 5x5: trailing row/column zero and never read
        clear_mon();
        send(1, 5, 5, 1, 0);
        wait_done(1, "b");
        check("b_len", 32'(cnt[1]), 32'd16);
        check("b_data", 32'(burst16(1)), 32'hFFFF);
        check("b_bursts", 32'(bursts[1]), 32'd1);

        // single pixel (2,1) lands at burst index 6
        clear_mon();
        send(0, 4, 4, 2, 0);
        wait_done(0, "a2");
        check("a2_len", 32'(cnt[0]), 32'd16);
        check("a2_data", 32'(burst16(0)), 32'h0200);

        // F=5 all-ones, second frame of zeros sent during readout is dropped
        clear_mon();
        send(2, 12, 11, 3, 0);
        send(2, 12, 11, 4, 0);
        wait_done(2, "c");
        check("c_len", 32'(cnt[2]), 32'd100);
        check("c_ones", 32'(ones[2]), 32'd100);
        check("c_bursts", 32'(bursts[2]), 32'd1);
        check("c_busy_after", 32'(bsy[2]), 32'd0);

        // stream joined at (0,2) is ignored, then a full frame
        clear_mon();
        send(0, 4, 4, 3, 8);
        check("a3_join_idle", 32'(bsy[0]), 32'd0);
        send(0, 4, 4, 0, 0);
        wait_done(0, "a3");
        check("a3_bursts", 32'(bursts[0]), 32'd1);
        check("a3_data", 32'(burst16(0)), 32'h5555);

        // reset at burst cycle 5, then a normal replay
        clear_mon();
        send(0, 4, 4, 3, 0);
        seen = 0;
        n    = 0;
        while (seen < 6 && n < 100) begin
            @(negedge clk);
            if (vds[0] === 1'b1) seen++;
            n++;
        end
        check("a4_reach_cycle5", 32'(seen), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        check("a4_valid_drop", 32'(vds[0]), 32'd0);
        check("a4_busy_drop", 32'(bsy[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();
        send(0, 4, 4, 0, 0);
        wait_done(0, "a4");
        check("a4_len", 32'(cnt[0]), 32'd16);
        check("a4_bursts", 32'(bursts[0]), 32'd1);
        check("a4_data", 32'(burst16(0)), 32'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mask_patch_serializer.md
Name: mask_patch_serializer

Overview:
- Upstream feeder for the downsample/threshold stage.
- Captures one full frame of the 1-bit hand-mask stream, which arrives in raster order, into an internal bit memory.
- Replays the frame in patch-serial order: FILTER_SIZE x FILTER_SIZE patches, patches row-major, pixels row-major inside each patch.
- valid_ds_out is held high continuously for the whole replay and low otherwise, because the downstream stage clears its counters whenever its valid input is low.

Parameters:
- FILTER_SIZE, 5, patch edge length in pixels.
- CAM_WIDTH, 240, mask frame width in pixels.
- CAM_HEIGHT, 320, mask frame height in pixels.
- Derived (localparam): DS_W = floor(CAM_WIDTH/FILTER_SIZE); DS_H = floor(CAM_HEIGHT/FILTER_SIZE); FILTER_AREA = FILTER_SIZE^2; READ_LEN = DS_W*DS_H*FILTER_AREA; MEM_DEPTH = CAM_WIDTH*CAM_HEIGHT.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_in  input  1  synchronous, active-high reset.
- hcount_in  input  11  column of incoming mask pixel, 0..CAM_WIDTH-1.
- vcount_in  input  10  row of incoming mask pixel, 0..CAM_HEIGHT-1.
- mask_in  input  1  incoming mask bit.
- valid_in  input  1  qualifies hcount_in/vcount_in/mask_in this cycle.
- mask_ds_out  output  1  patch-serial mask bit; feeds the downsample stage's mask input.
- valid_ds_out  output  1  high for exactly READ_LEN consecutive cycles per replayed frame.
- busy_out  output  1  high in CAPTURE, READ or DRAIN.

Behaviour:
- Reset, and every cycle rst_in is high:
  - state=IDLE.
  - valid_ds_out=0, mask_ds_out=0, busy_out=0.
  - All counters and the read pipeline cleared; memory contents not cleared.
- Memory: 1 bit wide, MEM_DEPTH deep, single port. Write address = vcount_in*CAM_WIDTH + hcount_in. Read latency is fixed at 2 cycles (address registered, output registered).
- IDLE:
  - Waits for valid_in=1 with hcount_in=0 and vcount_in=0.
  - That pixel is written and the state moves to CAPTURE.
  - Every other pixel seen in IDLE is ignored, so a frame joined mid-way is dropped.
- CAPTURE:
  - Every valid_in pixel with hcount_in<CAM_WIDTH and vcount_in<CAM_HEIGHT is written; out-of-range pixels are ignored.
  - Writing pixel (CAM_WIDTH-1, CAM_HEIGHT-1) moves the state to READ on the next cycle.
  - A new (0,0) pixel before frame end restarts capture (write it, stay in CAPTURE).
- READ:
  - Issues one read address per cycle for READ_LEN cycles with no gaps.
  - Nested counters, outermost first: pr 0..DS_H-1, pc 0..DS_W-1, dy 0..FILTER_SIZE-1, dx 0..FILTER_SIZE-1.
  - Address = (pr*FILTER_SIZE+dy)*CAM_WIDTH + pc*FILTER_SIZE + dx, maintained incrementally with a row-base register; no multipliers in the per-cycle path.
  - Rows at or above DS_H*FILTER_SIZE and columns at or above DS_W*FILTER_SIZE are never read.
  - All input pixels are ignored in READ.
  - After the last address (pr=DS_H-1, pc=DS_W-1, dy=dx=FILTER_SIZE-1) the state moves to DRAIN.
- DRAIN: lasts 2 cycles while the read pipeline empties, then returns to IDLE.
- Output timing:
  - valid_ds_out and mask_ds_out are the read-issue strobe and the memory data, both delayed 2 cycles.
  - valid_ds_out first rises 3 cycles after the final capture write.
  - It stays high for exactly READ_LEN cycles and falls in the cycle after the last valid bit.
  - mask_ds_out holds its last value while valid_ds_out=0.
- busy_out is 1 in CAPTURE, READ and DRAIN, and 0 only in IDLE.
- Frames arriving during READ or DRAIN are dropped whole. Capture resumes at the next (0,0) pixel seen in IDLE.
- Reset mid-READ: valid_ds_out drops on the next cycle and the replay is not resumed; the downstream stage clears itself on the low valid.

Test Plan:
- F=2, W=4, H=4, frame mask bits = row-major 0..15 bit[i]=i[0] (alternating columns) -> 16-cycle burst on mask_ds_out = 0,1,0,1 repeated 4 times; valid_ds_out high exactly 16 cycles, rising 3 cycles after pixel (3,3) is written.
- F=2, W=5, H=5, all-ones frame with column 4 and row 4 set to 0 -> 16-cycle burst, every bit 1 (trailing row and column never read).
- F=2, W=4, H=4, only pixel (2,1) set -> the single 1 appears at burst index 6 (patch 1, dy=1, dx=0).
- Default params, full frame of ones -> valid_ds_out high 76800 consecutive cycles, busy_out low afterwards; a second frame sent during the readout is absent from the output.
- Stream joined at pixel (0,2), then a complete frame -> only the complete frame is replayed; exactly one burst.
- rst_in pulsed at burst cycle 5 -> valid_ds_out=0 the following cycle, state IDLE; the next full frame replays normally.
